// File: rtl/io_ccff_pkg.sv
// Shared types and constants for the I/O configuration-chain loader.
// Pure declarations: no logic, no latency, no flow control.
package io_ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_ld_state_t;

    localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
    localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16_step.sv
// One-bit CRC-16-CCITT update, present only when CCFF_CRC_EN is defined.
// Combinational, zero latency; no flow control.
`ifdef CCFF_CRC_EN
module ccff_crc16_step
    import io_ccff_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic fb;

    assign fb      = crc_in[15] ^ bit_in;
    assign crc_out = {crc_in[14:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 16'h0000);

endmodule
`endif

// File: rtl/io_ccff_loader.sv
// Serializes configuration words MSB-first into one ccff chain with a gated prog_clk; optional CRC under CCFF_CRC_EN.
// Latency: CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from start to done with word_valid held high.
// Backpressure: word_ready only in LOAD; the chain clock stays gated while waiting for a word.
module io_ccff_loader
    import io_ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic                             prog_clk,
    input  logic                             pReset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                word_data,
    input  logic                             word_valid,
    output logic                             word_ready,
    output logic                             ccff_head,
    output logic                             chain_clk_en,
    input  logic                             ccff_tail,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bits_left
`ifdef CCFF_CRC_EN
    ,
    output logic [15:0]                      crc
`endif
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [BL_W-1:0] BL_ONE = BL_W'(1);
    localparam logic [WB_W-1:0] WB_ONE = WB_W'(1);

    ccff_ld_state_t    state_q;
    logic [WORD_W-1:0] sr_q;
    logic [WB_W-1:0]   word_bits_q;
    logic [WB_W-1:0]   word_bits_d;
    logic [BL_W-1:0]   bits_left_q;
    logic              head_q;
    logic              clk_en_q;
    logic              done_q;
    logic              aborted_q;

    // A short last word only contributes the bits the chain still needs.
    always_comb begin
        word_bits_d = WB_W'(WORD_W);
        if (int'(bits_left_q) < WORD_W) begin
            word_bits_d = WB_W'(bits_left_q);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            word_bits_q <= '0;
            bits_left_q <= '0;
            head_q      <= 1'b0;
            clk_en_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_LOAD;
                        bits_left_q <= BL_W'(CHAIN_LEN);
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        aborted_q   <= 1'b1;
                        bits_left_q <= '0;
                    end else if (word_valid) begin
                        head_q      <= word_data[WORD_W-1];
                        sr_q        <= word_data << 1;
                        word_bits_q <= word_bits_d;
                        clk_en_q    <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Abort beats the final shift so done never follows a cancelled load.
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        aborted_q   <= 1'b1;
                        clk_en_q    <= 1'b0;
                        bits_left_q <= '0;
                    end else begin
                        bits_left_q <= bits_left_q - BL_ONE;
                        word_bits_q <= word_bits_q - WB_ONE;
                        if (word_bits_q == WB_ONE) begin
                            clk_en_q <= 1'b0;
                            if (bits_left_q == BL_ONE) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end else begin
                            head_q <= sr_q[WORD_W-1];
                            sr_q   <= sr_q << 1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_ready   = (state_q == ST_LOAD);
    assign busy         = (state_q != ST_IDLE);
    assign ccff_head    = head_q;
    assign chain_clk_en = clk_en_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign bits_left    = bits_left_q;

`ifdef CCFF_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        tail_unused_q;

    ccff_crc16_step u_crc_step (
        .crc_in  (crc_q),
        .bit_in  (head_q),
        .crc_out (crc_d)
    );

    // Tail is captured for a future readback path and otherwise ignored.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc_q         <= CCFF_CRC_INIT;
            tail_unused_q <= 1'b0;
        end else begin
            tail_unused_q <= ccff_tail;
            if (state_q == ST_IDLE && start) begin
                crc_q <= CCFF_CRC_INIT;
            end else if (clk_en_q) begin
                crc_q <= crc_d;
            end
        end
    end

    assign crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_io_ccff_loader.sv
// Bench for io_ccff_loader: three chain lengths (8, 20, 16) share stimulus, one load at a time.
// Directed vector table plus randomized loads checked against a bit-stream model.
module tb_io_ccff_loader;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       abort;
    logic [7:0] word_data;
    logic       word_valid;
    logic       ccff_tail;
    logic       start_v [3];

    logic       head_w [3];
    logic       en_w   [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       abd_w  [3];
    logic       rdy_w  [3];
    logic [3:0] bl_a;
    logic [4:0] bl_b;
    logic [4:0] bl_c;
`ifdef CCFF_CRC_EN
    logic [15:0] crc_w [3];
    logic [15:0] v_crc;
`endif

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int cur   = 0;

    logic       v_head, v_en, v_busy, v_done, v_abd, v_rdy;
    logic [4:0] v_bl;
    logic [7:0] wv [3];

    always #5 prog_clk = ~prog_clk;

    io_ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_v[0]), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy_w[0]),
        .ccff_head(head_w[0]), .chain_clk_en(en_w[0]), .ccff_tail(ccff_tail),
        .busy(busy_w[0]), .done(done_w[0]), .aborted(abd_w[0]), .bits_left(bl_a)
`ifdef CCFF_CRC_EN
        , .crc(crc_w[0])
`endif
    );

    io_ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_v[1]), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy_w[1]),
        .ccff_head(head_w[1]), .chain_clk_en(en_w[1]), .ccff_tail(ccff_tail),
        .busy(busy_w[1]), .done(done_w[1]), .aborted(abd_w[1]), .bits_left(bl_b)
`ifdef CCFF_CRC_EN
        , .crc(crc_w[1])
`endif
    );

    io_ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_c (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_v[2]), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy_w[2]),
        .ccff_head(head_w[2]), .chain_clk_en(en_w[2]), .ccff_tail(ccff_tail),
        .busy(busy_w[2]), .done(done_w[2]), .aborted(abd_w[2]), .bits_left(bl_c)
`ifdef CCFF_CRC_EN
        , .crc(crc_w[2])
`endif
    );

    always_comb begin
        v_head = head_w[sel];
        v_en   = en_w[sel];
        v_busy = busy_w[sel];
        v_done = done_w[sel];
        v_abd  = abd_w[sel];
        v_rdy  = rdy_w[sel];
        v_bl   = (sel == 0) ? {1'b0, bl_a} : (sel == 1) ? bl_b : bl_c;
`ifdef CCFF_CRC_EN
        v_crc  = crc_w[sel];
`endif
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (case %0d, sel %0d): got %0h expected %0h", name, cur, sel, act, exp);
        end
    endtask

    function automatic int len_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 20 : 16;
    endfunction

    // Reference: the chain receives the concatenated words MSB-first, truncated to n bits.
    function automatic logic [31:0] model_stream(input int n);
        logic [31:0] r;
        logic [7:0]  w;
        r = '0;
        for (int i = 0; i < n; i++) begin
            w = wv[i / 8];
            r = {r[30:0], w[7 - (i % 8)]};
        end
        return r;
    endfunction

`ifdef CCFF_CRC_EN
    function automatic logic [15:0] crc_model(input logic [31:0] s, input int n);
        int c;
        int b;
        c = 'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = int'(s[n - 1 - i]);
            c = ((c << 1) & 'hFFFF) ^ ((((c >> 15) & 1) ^ b) != 0 ? 'h1021 : 0);
        end
        return c[15:0];
    endfunction
`endif

    task automatic run_load(input int s, input int stall_n, input int stall_pct,
                            input int abort_after, input bit poke,
                            output logic [31:0] got, output int nbits, output int lat,
                            output bit saw_done, output bit saw_abort, output int stalls);
        int L, nw, widx, shifted, cyc, forced;
        bit prev_hs, hs;
        L = len_of(s); nw = (L + 7) / 8;
        widx = 0; shifted = 0; forced = 0; stalls = 0; prev_hs = 1'b0;
        got = '0; nbits = 0; lat = 0; saw_done = 1'b0; saw_abort = 1'b0;
        sel = s;
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
        cyc = 1;
        chk("busy_after_start", 32'(v_busy), 32'd1);
`ifdef CCFF_CRC_EN
        chk("crc_reinit", 32'(v_crc), 32'hFFFF);
`endif
        while (cyc < 400) begin
            if (v_done) begin
                saw_done = 1'b1;
                lat = cyc;
                break;
            end
            if (v_abd) begin
                saw_abort = 1'b1;
                break;
            end
            chk("bits_left", 32'(v_bl), 32'(L - shifted));
            chk("en_while_ready", 32'(v_en & v_rdy), 32'd0);
            if (prev_hs) chk("shift_after_hs", 32'(v_en), 32'd1);
            if (v_en) begin
                got = {got[30:0], v_head};
                nbits++;
                shifted++;
            end
            abort = (abort_after > 0) && v_en && (shifted == abort_after);
            start_v[s] = poke && v_en && (shifted == 2);
            if (widx < nw && v_rdy && forced < stall_n) begin
                word_valid = 1'b0;
                forced++;
            end else begin
                word_valid = (widx < nw) && ($urandom_range(99) >= stall_pct);
            end
            word_data = (widx < nw) ? wv[widx] : 8'h00;
            hs = word_valid && v_rdy && !abort;
            if (v_rdy && !word_valid && !abort) stalls++;
            if (hs) widx++;
            prev_hs = hs;
            tick();
            cyc++;
        end
        abort = 1'b0;
        word_valid = 1'b0;
        start_v[s] = 1'b0;
        if (!saw_done && !saw_abort) begin
            total++;
            bad++;
            $display("FAIL timeout (case %0d, sel %0d): no done or aborted after %0d cycles", cur, s, cyc);
        end
    endtask

    typedef struct {
        int          s;
        logic [7:0]  w0, w1, w2;
        int          stall_n;
        int          abort_after;
        logic [31:0] exp_bits;
        int          exp_n;
        int          exp_lat;
        bit          exp_done;
    } vec_t;

    vec_t        tv [9];
    logic [31:0] got, ms;
    int          n, lat, stalls, L, ab, en_n;
    bit          sd, sa;

    initial begin
        tv[0] = '{0, 8'hA5, 8'h00, 8'h00, 0, 0,  32'hA5,    8,  10, 1'b1};
        tv[1] = '{1, 8'hFF, 8'h00, 8'h9F, 0, 0,  32'hFF009, 20, 24, 1'b1};
        tv[2] = '{2, 8'hA5, 8'h3C, 8'h00, 0, 0,  32'hA53C,  16, 19, 1'b1};
        tv[3] = '{0, 8'h3C, 8'h00, 8'h00, 5, 0,  32'h3C,    8,  15, 1'b1};
        tv[4] = '{1, 8'h12, 8'h34, 8'h56, 5, 0,  32'h12345, 20, 29, 1'b1};
        tv[5] = '{0, 8'hA5, 8'h00, 8'h00, 0, 3,  32'h5,     3,  0,  1'b0};
        tv[6] = '{1, 8'h81, 8'h7E, 8'hF0, 0, 20, 32'h817EF, 20, 0,  1'b0};
        tv[7] = '{2, 8'h00, 8'hFF, 8'h00, 2, 0,  32'h00FF,  16, 21, 1'b1};
        tv[8] = '{0, 8'hFF, 8'h00, 8'h00, 0, 8,  32'hFF,    8,  0,  1'b0};

        pReset = 1'b1; abort = 1'b0; word_data = 8'h00; word_valid = 1'b0; ccff_tail = 1'b0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_ready", 32'(v_rdy), 32'd0);
            chk("rst_head", 32'(v_head), 32'd0);
            chk("rst_en", 32'(v_en), 32'd0);
            chk("rst_busy", 32'(v_busy), 32'd0);
            chk("rst_done_abort", 32'({v_done, v_abd}), 32'd0);
            chk("rst_bits_left", 32'(v_bl), 32'd0);
`ifdef CCFF_CRC_EN
            chk("rst_crc", 32'(v_crc), 32'hFFFF);
`endif
        end
        pReset = 1'b0;
        tick();

        sel = 0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", 32'({v_abd, v_busy}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            cur = i;
            wv[0] = tv[i].w0; wv[1] = tv[i].w1; wv[2] = tv[i].w2;
            run_load(tv[i].s, tv[i].stall_n, 0, tv[i].abort_after, tv[i].abort_after > 0,
                     got, n, lat, sd, sa, stalls);
            chk("done_seen", 32'(sd), 32'(tv[i].exp_done));
            chk("aborted_seen", 32'(sa), 32'(!tv[i].exp_done));
            chk("stream", got, tv[i].exp_bits);
            chk("nbits", 32'(n), 32'(tv[i].exp_n));
            if (tv[i].exp_done) begin
                chk("latency", 32'(lat), 32'(tv[i].exp_lat));
                chk("busy_in_done", 32'(v_busy), 32'd1);
                chk("en_in_done", 32'(v_en), 32'd0);
`ifdef CCFF_CRC_EN
                chk("crc_at_done", 32'(v_crc), 32'(crc_model(tv[i].exp_bits, tv[i].exp_n)));
`endif
            end else begin
                chk("idle_after_abort", 32'(v_busy), 32'd0);
                chk("en_after_abort", 32'(v_en), 32'd0);
                chk("no_done_on_abort", 32'(v_done), 32'd0);
            end
            tick();
            chk("pulse_one_cycle", 32'({v_done, v_abd}), 32'd0);
            chk("idle_after", 32'(v_busy), 32'd0);
`ifdef CCFF_CRC_EN
            if (tv[i].exp_done) chk("crc_hold", 32'(v_crc), 32'(crc_model(tv[i].exp_bits, tv[i].exp_n)));
`endif
            tick();
        end

        // Reset in the middle of a shift, then a clean load on the same chain.
        cur = 100;
        sel = 1;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        word_valid = 1'b1;
        word_data = 8'hC3;
        repeat (4) tick();
        chk("mid_shift_en", 32'(v_en), 32'd1);
        pReset = 1'b1;
        #1;
        chk("mid_rst_en_head", 32'({v_en, v_head}), 32'd0);
        chk("mid_rst_busy_ready", 32'({v_busy, v_rdy}), 32'd0);
        chk("mid_rst_bits_left", 32'(v_bl), 32'd0);
`ifdef CCFF_CRC_EN
        chk("mid_rst_crc", 32'(v_crc), 32'hFFFF);
`endif
        word_valid = 1'b0;
        tick();
        chk("mid_rst_no_pulse", 32'({v_done, v_abd}), 32'd0);
        pReset = 1'b0;
        tick();
        wv[0] = 8'hC3; wv[1] = 8'h5A; wv[2] = 8'h70;
        run_load(1, 0, 0, 0, 1'b0, got, n, lat, sd, sa, stalls);
        chk("post_rst_done", 32'(sd), 32'd1);
        chk("post_rst_stream", got, 32'hC35A7);
        chk("post_rst_latency", 32'(lat), 32'd24);
        tick();
        tick();

        for (int it = 0; it < 40; it++) begin
            cur = 200 + it;
            sel = $urandom_range(2);
            L = len_of(sel);
            for (int k = 0; k < 3; k++) wv[k] = 8'($urandom);
            ab = ($urandom_range(3) == 0) ? $urandom_range(L, 1) : 0;
            en_n = (ab > 0) ? ab : L;
            ms = model_stream(en_n);
            run_load(sel, 0, $urandom_range(40), ab, 1'b0, got, n, lat, sd, sa, stalls);
            chk("rnd_done", 32'(sd), 32'(ab == 0));
            chk("rnd_stream", got, ms);
            chk("rnd_nbits", 32'(n), 32'(en_n));
            if (sd) begin
                chk("rnd_latency", 32'(lat), 32'(L + (L + 7) / 8 + 1 + stalls));
`ifdef CCFF_CRC_EN
                chk("rnd_crc", 32'(v_crc), 32'(crc_model(ms, en_n)));
`endif
            end
            tick();
            chk("rnd_idle", 32'({v_busy, v_done, v_abd}), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_ccff_loader.md
# io_ccff_loader

Configuration-chain loader for the I/O grid tiles. It accepts configuration words over a valid/ready stream, serializes them MSB-first onto the tile's `ccff_head`, and gates the chain's programming clock so that exactly `CHAIN_LEN` bits are shifted. It sits between the bitstream source and one `ccff_head`/`ccff_tail` chain, for example the 8-subtile right-side I/O column. It pulses `done` when the chain holds the new configuration.

## Interface
Parameters:
- `CHAIN_LEN`, default 8: number of configuration flops in the driven chain; must be ≥ 1.
- `WORD_W`, default 8: input word width; must be ≥ 1.

Ports:
- `prog_clk`, input, 1: programming clock; all state updates on its rising edge.
- `pReset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle request to begin a load; sampled only in IDLE.
- `abort`, input, 1: synchronous cancel of a load in progress.
- `word_data`, input, WORD_W: configuration word; bit `WORD_W-1` is shifted first.
- `word_valid`, input, 1: `word_data` is valid.
- `word_ready`, output, 1: loader accepts a word this cycle.
- `ccff_head`, output, 1: serial data driven into the chain head.
- `chain_clk_en`, output, 1: enable for the chain's gated `prog_clk`.
- `ccff_tail`, input, 1: chain tail; only observed when `CCFF_CRC_EN` is defined.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the load completes.
- `aborted`, output, 1: one-cycle pulse when a load is cancelled.
- `bits_left`, output, $clog2(CHAIN_LEN+1): chain bits still to shift.
- `crc`, output, 16: only present when `CCFF_CRC_EN` is defined.

## Operation
- **States:** IDLE, LOAD, SHIFT, DONE.
- **IDLE → LOAD:** on `start`, load `bits_left` with CHAIN_LEN. `start` is ignored in every other state.
- **LOAD:**
  - `word_ready`=1 and `chain_clk_en`=0.
  - On `word_valid & word_ready`, latch `word_data` into the shift register, set `word_bits` to min(WORD_W, `bits_left`), then go to SHIFT.
  - If `word_valid` is low, stay in LOAD; the chain does not shift.
- **SHIFT:** each cycle:
  - `ccff_head` = shift register MSB, `chain_clk_en`=1.
  - Shift the register left by one, and decrement both `word_bits` and `bits_left`.
  - When `word_bits` reaches 0: if `bits_left`>0 go to LOAD, otherwise go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Partial last word:** when CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the last word are shifted. The remaining bits are discarded.
- **Abort:** in LOAD or SHIFT, `abort` forces IDLE on the next edge.
  - `chain_clk_en` drops at that same edge.
  - `aborted` pulses for one cycle; `done` is not asserted.
  - Chain contents are undefined after an abort.
- **Abort priority:** if `abort` coincides with the final shift, abort wins. In IDLE or DONE, `abort` has no effect.
- **Stream order:** the first bit shifted ends up in the flop nearest `ccff_tail`.

## Timing
- **Registered outputs:** `ccff_head` and `chain_clk_en` are registered, stable for a full cycle, and change only on `prog_clk` rising edges. The chain captures `ccff_head` at the edge ending each cycle in which `chain_clk_en`=1.
- **Reset values:** IDLE state, and `word_ready`, `ccff_head`, `chain_clk_en`, `busy`, `done`, `aborted` all 0. `bits_left`=0. `crc`=16'hFFFF.
- **Handshake:** `word_ready` is combinational from state (high only in LOAD). A word transfers on an edge where both `word_valid` and `word_ready` are high.
- **Latency with `word_valid` held high:**
  - `start` sampled at edge 0; first word accepted at edge 1.
  - SHIFT occupies CHAIN_LEN cycles plus one LOAD bubble per additional word.
  - `done` is high for the cycle after the last shift.
  - Total = CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from `start` to `done`.
- **Mid-operation reset:** asserting `pReset` returns everything to reset values immediately. No `done` or `aborted` pulse is produced.

## Configuration
- **Macro:** `CCFF_CRC_EN`.
- **When defined:**
  - The `crc` port exists.
  - `crc` is CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, no final XOR), updated with each `ccff_head` bit in shift order.
  - It re-initialises on accepted `start` and is held stable from `done` until the next `start`.
  - `ccff_tail` is sampled and ignored; the port is reserved for a future readback.
- **When undefined:** no `crc` port and no CRC logic. `ccff_tail` is unused.

## Structure
- **Package `io_ccff_pkg`:** state enum `ccff_ld_state_t`, `CCFF_CRC_POLY` = 16'h1021, and `CCFF_CRC_INIT` = 16'hFFFF.
- **Sub-module `ccff_crc16_step`:** combinational one-bit CRC update (`crc_in`, `bit_in` → `crc_out`). It is instantiated only under `CCFF_CRC_EN`.

## Test plan
- **Single word, exact fit:** CHAIN_LEN=8, WORD_W=8, word 0xA5, `word_valid` held high → `ccff_head` = 1,0,1,0,0,1,0,1 over 8 cycles with `chain_clk_en`=1. `done` pulses 10 cycles after `start`. A chain model's contents equal 0xA5.
- **Partial last word:** CHAIN_LEN=20, words 0xFF, 0x00, 0x9F → exactly 20 enabled cycles with pattern 8×1, 8×0, 1,0,0,1. The low nibble 0xF is never driven. Exactly one LOAD bubble with `chain_clk_en`=0 between words.
- **Backpressure:** `word_valid` low for 5 cycles in LOAD → `chain_clk_en` stays 0 and `bits_left` stays frozen. Shifting resumes on the cycle after the handshake.
- **Abort:** `abort` after 3 shifts of an 8-bit load → IDLE next edge, `aborted`=1 for one cycle, no `done`. A `start` during busy is ignored.
- **Reset mid-load:** assert `pReset` mid-SHIFT → all outputs at reset values immediately. A subsequent full load completes normally.
- **CRC (`CCFF_CRC_EN` defined):** load 0xA5 then 0x3C with CHAIN_LEN=16 → `crc` at `done` matches the bit-serial CCITT model. `crc` returns to 0xFFFF on the next `start`.
